// File: rtl/spi_sp_ram.sv
// spi_sp_ram: single-port RAM behind the SPI slave; decodes 10-bit commands.
// Define SPI_RAM_ADDR_AUTO_INC_EN to enable address auto-increment.
module spi_sp_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       cmd_err
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_e;

    localparam logic [ADDR_SIZE:0] DEPTH = (ADDR_SIZE+1)'(MEM_DEPTH);

`ifdef SPI_RAM_ADDR_AUTO_INC_EN
    localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_DEPTH - 1);

    // Wrap at the last implemented word, not at the address-width limit.
    function automatic logic [ADDR_SIZE-1:0] bump(
        input logic [ADDR_SIZE-1:0] a
    );
        return (a == LAST) ? '0 : a + ADDR_SIZE'(1);
    endfunction
`endif

    logic [7:0]           mem [MEM_DEPTH];
    logic [ADDR_SIZE-1:0] wr_addr;
    logic [ADDR_SIZE-1:0] rd_addr;
    logic [ADDR_SIZE-1:0] wr_addr_nxt;
    logic [ADDR_SIZE-1:0] rd_addr_nxt;
    logic [ADDR_SIZE-1:0] cmd_addr;
    logic                 rd_armed;
    logic                 rd_armed_nxt;
    logic                 addr_ok;
    logic                 do_write;
    logic                 do_read;
    logic                 err_nxt;
    cmd_e                 cmd;

    assign cmd      = cmd_e'(din[9:8]);
    assign cmd_addr = din[ADDR_SIZE-1:0];
    assign addr_ok  = {1'b0, cmd_addr} < DEPTH;

    always_comb begin
        wr_addr_nxt  = wr_addr;
        rd_addr_nxt  = rd_addr;
        rd_armed_nxt = rd_armed;
        do_write     = 1'b0;
        do_read      = 1'b0;
        err_nxt      = 1'b0;
        if (rx_valid) begin
            unique case (cmd)
                CMD_WR_ADDR: begin
                    if (addr_ok) wr_addr_nxt = cmd_addr;
                    else         err_nxt     = 1'b1;
                end
                CMD_WR_DATA: begin
                    do_write = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                    wr_addr_nxt = bump(wr_addr);
`endif
                end
                CMD_RD_ADDR: begin
                    if (addr_ok) begin
                        rd_addr_nxt  = cmd_addr;
                        rd_armed_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                CMD_RD_DATA: begin
                    if (rd_armed) begin
                        do_read = 1'b1;
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
                        rd_addr_nxt = bump(rd_addr);
`endif
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr  <= '0;
            rd_addr  <= '0;
            rd_armed <= 1'b0;
            dout     <= 8'h00;
            tx_valid <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            wr_addr  <= wr_addr_nxt;
            rd_addr  <= rd_addr_nxt;
            rd_armed <= rd_armed_nxt;
            tx_valid <= do_read;
            cmd_err  <= err_nxt;
            if (do_read) dout <= mem[rd_addr];
        end
    end

    // Storage is deliberately not reset; a command seen during reset is dropped.
    always_ff @(posedge clk) begin
        if (do_write && !rst) mem[wr_addr] <= din[7:0];
    end

endmodule

// File: tb/tb_spi_sp_ram.sv
// Scoreboard bench for spi_sp_ram: a 256-word and a 200-word instance.
// Expectations follow SPI_RAM_ADDR_AUTO_INC_EN when it is defined.
module tb_spi_sp_ram;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rxv_a, rxv_b;
    logic [7:0] dout_a, dout_b;
    logic       tx_a, tx_b, err_a, err_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] q_a[$];
    logic [9:0] q_b[$];

    localparam logic [9:0] EV_ERR = 10'b01_0000_0000;

    always #5 clk = ~clk;

    spi_sp_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rxv_a),
        .dout(dout_a), .tx_valid(tx_a), .cmd_err(err_a)
    );

    spi_sp_ram #(.MEM_DEPTH(200), .ADDR_SIZE(8)) u_dut_b (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rxv_b),
        .dout(dout_b), .tx_valid(tx_b), .cmd_err(err_b)
    );

    function automatic logic [9:0] ev_tx(input logic [7:0] d);
        return {2'b10, d};
    endfunction

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Monitors: every tx_valid/cmd_err pulse must match the next queued event.
    always @(negedge clk) begin
        if (rst === 1'b0 && (tx_a || err_a)) begin
            logic [9:0] got;
            got = {tx_a, err_a, tx_a ? dout_a : 8'h00};
            n_checks++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL mon_a: got event %h expected none", got);
            end else begin
                logic [9:0] e;
                e = q_a.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mon_a: got event %h expected %h", got, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && (tx_b || err_b)) begin
            logic [9:0] got;
            got = {tx_b, err_b, tx_b ? dout_b : 8'h00};
            n_checks++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL mon_b: got event %h expected none", got);
            end else begin
                logic [9:0] e;
                e = q_b.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL mon_b: got event %h expected %h", got, e);
                end
            end
        end
    end

    task automatic send_a(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        din   = {c, p};
        rxv_a = 1'b1;
        rxv_b = 1'b0;
    endtask

    task automatic send_b(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        din   = {c, p};
        rxv_a = 1'b0;
        rxv_b = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rxv_a = 1'b0;
            rxv_b = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        din   = '0;
        rxv_a = 1'b0;
        rxv_b = 1'b0;
        #3;
        chk("rst_dout", dout_a, 8'h00);
        chk("rst_tx", {7'd0, tx_a}, 8'h00);
        chk("rst_err", {7'd0, err_a}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Read data before any read address
        send_a(2'b11, 8'h00); q_a.push_back(EV_ERR);
        idle(2);

        // Write/read
        send_a(2'b00, 8'h3C);
        send_a(2'b01, 8'hA5);
        send_a(2'b10, 8'h3C);
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'hA5));
        idle(2);

        // Back-to-back, with 0x3D preloaded for the incrementing build
        send_a(2'b00, 8'h3D);
        send_a(2'b01, 8'hA5);
        send_a(2'b00, 8'h3C);
        send_a(2'b01, 8'hA5);
        send_a(2'b10, 8'h3C);
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'hA5));
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'hA5));
        idle(3);
        chk("dout_hold", dout_a, 8'hA5);

        // Auto-increment sequence
        send_a(2'b00, 8'hFF);
        send_a(2'b01, 8'h01);
        send_a(2'b01, 8'h02);
        send_a(2'b10, 8'hFF);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'h01));
`else
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'h02));
`endif
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'h02));
        idle(2);
        chk("dout_autoinc", dout_a, 8'h02);

        // Async reset while tx_valid is high
        send_a(2'b00, 8'h05);
        send_a(2'b01, 8'h5A);
        send_a(2'b10, 8'h05);
        send_a(2'b11, 8'h00);
        @(posedge clk);
        #2;
        rxv_a = 1'b0;
        chk("pre_rst_tx", {7'd0, tx_a}, 8'h01);
        chk("pre_rst_dout", dout_a, 8'h5A);
        rst = 1'b1;
        #1;
        chk("async_rst_dout", dout_a, 8'h00);
        chk("async_rst_tx", {7'd0, tx_a}, 8'h00);
        chk("async_rst_err", {7'd0, err_a}, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        // Arm cleared by reset; memory survives
        send_a(2'b11, 8'h00); q_a.push_back(EV_ERR);
        send_a(2'b10, 8'h05);
        send_a(2'b11, 8'h00); q_a.push_back(ev_tx(8'h5A));
        idle(2);

        // Command sampled while rst is high is discarded
        @(negedge clk);
        rst   = 1'b1;
        din   = {2'b10, 8'h05};
        rxv_a = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        rxv_a = 1'b0;
        send_a(2'b11, 8'h00); q_a.push_back(EV_ERR);
        idle(2);
        chk("dout_after_err", dout_a, 8'h00);

        // 200-word instance: out-of-range addresses
        send_b(2'b00, 8'h10);
        send_b(2'b00, 8'hC8); q_b.push_back(EV_ERR);
        send_b(2'b01, 8'h11);
        send_b(2'b10, 8'hC8); q_b.push_back(EV_ERR);
        send_b(2'b11, 8'h00); q_b.push_back(EV_ERR);
        send_b(2'b10, 8'h10);
        send_b(2'b11, 8'h00); q_b.push_back(ev_tx(8'h11));

        // Last word and wrap
        send_b(2'b00, 8'hC7);
        send_b(2'b01, 8'h77);
        send_b(2'b01, 8'h66);
        send_b(2'b10, 8'hC7);
`ifdef SPI_RAM_ADDR_AUTO_INC_EN
        send_b(2'b11, 8'h00); q_b.push_back(ev_tx(8'h77));
`else
        send_b(2'b11, 8'h00); q_b.push_back(ev_tx(8'h66));
`endif
        send_b(2'b11, 8'h00); q_b.push_back(ev_tx(8'h66));
        idle(3);
        chk("b_dout_hold", dout_b, 8'h66);
        send_b(2'b00, 8'hFF); q_b.push_back(EV_ERR);
        idle(3);
        chk("b_dout_after_err", dout_b, 8'h66);

        idle(3);
        chk("q_a_drained", 8'(q_a.size()), 8'h00);
        chk("q_b_drained", 8'(q_b.size()), 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
